// File: rtl/fifo_flex_if.sv
// Handshake bundle between a fifo_flex instance and its producer/consumer.
// The master side drives write/read requests and error clear; the slave
// side (the FIFO) returns data, occupancy and status flags.
interface fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, full, almost_full, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, full, almost_full, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with registered-read or first-word-fall-through
// output, occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. Storage is not cleared by reset; only the pointers,
// count, output register and error flags are.
module fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_flex_if.slave   bus
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             emptyW;
    logic             fullW;
    logic             rdOk;
    logic             wrOk;

    // Status flags are pure functions of the registered occupancy.
    assign emptyW = (count_q == '0);
    assign fullW  = (count_q == CNT_W'(DEPTH));

    // A read needs data; a write needs room, or a slot freed by a same-edge read.
    assign rdOk = bus.rd_en && !emptyW;
    assign wrOk = bus.wr_en && (!fullW || rdOk);

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q && !bus.clr_err) || (bus.wr_en && !wrOk);
        underflow_d = (underflow_q && !bus.clr_err) || (bus.rd_en && emptyW);

        if (rdOk) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (wrOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        unique case ({wrOk, rdOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; async reset discards all stored contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, written only on an accepted write; no reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (wrOk) begin
            mem[wrPtr_q] <= bus.din;
        end
    end

    generate
        if (FWFT != 0) begin : gFwft
            // Head entry is presented directly; driven to zero while empty for determinism.
            assign bus.dout = emptyW ? '0 : mem[rdPtr_q];
        end else begin : gRegRead
            logic [WIDTH-1:0] dout_q;

            // Output register loads the head entry on an accepted read and holds otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rdOk) begin
                    dout_q <= mem[rdPtr_q];
                end
            end

            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.empty        = emptyW;
    assign bus.full         = fullW;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
